// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage: MIPS instruction-fetch stage with PC, IF/ID register and halt detection.
// Ports: clk, rst_n (async active-low); imem_addr/imem_instr to the combinational
// instruction memory; stall, flush, redirect_valid/redirect_pc from downstream;
// ifid_instr/ifid_pc_plus4/ifid_valid IF/ID register; halted status;
// fetch_count valid-load counter, present only when FETCH_PERF_CNT_EN is defined.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state;
  logic [31:0] pc, pc_plus4;
  logic squash, load, halt_hit;
  assign imem_addr = pc;
  assign pc_plus4 = pc + 32'd4;
  assign squash = redirect_valid | flush;
  assign load = !squash && !stall && state == RUN;
  assign halt_hit = load && imem_instr[31:26] == HALT_OPCODE;
  // A fetched halt freezes the PC on its own address until a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc <= RESET_PC;
      halted <= 1'b0;
      ifid_instr <= '0;
      ifid_pc_plus4 <= '0;
      ifid_valid <= 1'b0;
    end else begin
      pc <= redirect_valid ? (redirect_pc & ~32'd3) :
            (stall || state == HALT || halt_hit) ? pc : pc_plus4;
      state <= redirect_valid ? RUN : halt_hit ? HALT : state;
      halted <= redirect_valid ? 1'b0 : halt_hit ? 1'b1 : halted;
      if (squash || (!stall && state == HALT)) begin
        ifid_instr <= '0;
        ifid_pc_plus4 <= '0;
        ifid_valid <= 1'b0;
      end else if (load) begin
        ifid_instr <= imem_instr;
        ifid_pc_plus4 <= pc_plus4;
        ifid_valid <= 1'b1;
      end
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_count <= '0;
    else if (load) fetch_count <= fetch_count + 32'd1;
  end
`endif
endmodule
